// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - elastic MEM->WB stage with 2-entry skid buffer and write-back select
module mem_wb_stage #(
    parameter int DATA_W    = 32,
    parameter int REG_AW    = 5,
    parameter int ZERO_GATE = 1
) (
    input  logic                          clk,
    input  logic                          clr,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_reg_write,
    input  logic                          in_mem_to_reg,
    input  logic [REG_AW-1:0]             in_write_reg,
    input  logic [DATA_W-1:0]             in_alu_out,
    input  logic [DATA_W-1:0]             in_dm_out,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_reg_write,
    output logic                          out_mem_to_reg,
    output logic [REG_AW-1:0]             out_write_reg,
    output logic [DATA_W-1:0]             out_wb_data,
    output logic [2+REG_AW+2*DATA_W-1:0]  out_pkt,
    output logic                          fwd_hit_valid
);

    localparam int PKT_W = 2 + REG_AW + 2 * DATA_W;

    // Field order matches the legacy packed bus, LSB first: reg_write, mem_to_reg, write_reg, alu, dm.
    typedef struct packed {
        logic [DATA_W-1:0] dm_out;
        logic [DATA_W-1:0] alu_out;
        logic [REG_AW-1:0] write_reg;
        logic              mem_to_reg;
        logic              reg_write;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t     state;
    entry_t     head;
    entry_t     skid;
    entry_t     in_entry;
    logic       zero_dest;
    logic       accept;
    logic       pop;
    logic [PKT_W-1:0] head_bits;

    assign zero_dest = (in_write_reg == '0);
    assign accept    = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready;

    always_comb begin
        in_entry            = '0;
        in_entry.reg_write  = in_reg_write & ~((ZERO_GATE != 0) & zero_dest);
        in_entry.mem_to_reg = in_mem_to_reg;
        in_entry.write_reg  = in_write_reg;
        in_entry.alu_out    = in_alu_out;
        in_entry.dm_out     = in_dm_out;
    end

    // in_ready and out_valid are flopped from the next occupancy so no ready path is combinational.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= EMPTY;
            head      <= '0;
            skid      <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else if (flush) begin
            state     <= EMPTY;
            head      <= '0;
            skid      <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        head      <= in_entry;
                        state     <= ONE;
                        out_valid <= 1'b1;
                    end
                end
                ONE: begin
                    if (accept && !pop) begin
                        skid     <= in_entry;
                        state    <= TWO;
                        in_ready <= 1'b0;
                    end else if (accept) begin
                        head <= in_entry;
                    end else if (pop) begin
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                TWO: begin
                    if (pop) begin
                        head     <= skid;
                        state    <= ONE;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign head_bits      = head;
    assign out_reg_write  = head.reg_write & out_valid;
    assign out_mem_to_reg = head.mem_to_reg & out_valid;
    assign out_write_reg  = out_valid ? head.write_reg : '0;
    assign out_wb_data    = out_valid ? (head.mem_to_reg ? head.dm_out : head.alu_out) : '0;
    assign out_pkt        = out_valid ? head_bits : '0;
    assign fwd_hit_valid  = out_reg_write;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - scoreboard bench for mem_wb_stage with gated and ungated $0 instances
module tb_mem_wb_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        clr, flush, in_valid, in_reg_write, in_mem_to_reg, out_ready;
    logic [4:0]  in_write_reg;
    logic [31:0] in_alu_out, in_dm_out;

    logic        in_ready_g, out_valid_g, out_reg_write_g, out_mem_to_reg_g, fwd_g;
    logic [4:0]  out_write_reg_g;
    logic [31:0] out_wb_data_g;
    logic [70:0] out_pkt_g;
    logic        in_ready_u, out_valid_u, out_reg_write_u, out_mem_to_reg_u, fwd_u;
    logic [4:0]  out_write_reg_u;
    logic [31:0] out_wb_data_u;
    logic [70:0] out_pkt_u;

    mem_wb_stage #(.DATA_W(32), .REG_AW(5), .ZERO_GATE(1)) dut (
        .clk(clk), .clr(clr), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_g),
        .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg), .in_write_reg(in_write_reg),
        .in_alu_out(in_alu_out), .in_dm_out(in_dm_out), .out_valid(out_valid_g), .out_ready(out_ready),
        .out_reg_write(out_reg_write_g), .out_mem_to_reg(out_mem_to_reg_g), .out_write_reg(out_write_reg_g),
        .out_wb_data(out_wb_data_g), .out_pkt(out_pkt_g), .fwd_hit_valid(fwd_g)
    );

    mem_wb_stage #(.DATA_W(32), .REG_AW(5), .ZERO_GATE(0)) dut_nogate (
        .clk(clk), .clr(clr), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_u),
        .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg), .in_write_reg(in_write_reg),
        .in_alu_out(in_alu_out), .in_dm_out(in_dm_out), .out_valid(out_valid_u), .out_ready(out_ready),
        .out_reg_write(out_reg_write_u), .out_mem_to_reg(out_mem_to_reg_u), .out_write_reg(out_write_reg_u),
        .out_wb_data(out_wb_data_u), .out_pkt(out_pkt_u), .fwd_hit_valid(fwd_u)
    );

    typedef struct {
        logic        rw;
        logic        m2r;
        logic [4:0]  wr;
        logic [31:0] alu;
        logic [31:0] dm;
    } ent_t;

    ent_t q[$];
    ent_t e;
    int   total = 0;
    int   bad = 0;
    bit   mon_on = 1'b0;
    logic rwg;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Monitor: the queue holds exactly what the stage should be holding, head first.
    always @(negedge clk) begin
        if (mon_on && !clr) begin
            chk("in_ready", in_ready_g, q.size() < 2);
            chk("in_ready_u", in_ready_u, q.size() < 2);
            chk("out_valid", out_valid_g, q.size() != 0);
            chk("out_valid_u", out_valid_u, q.size() != 0);
            if (q.size() != 0) begin
                e   = q[0];
                rwg = e.rw && (e.wr != 5'd0);
                chk("reg_write", out_reg_write_g, rwg);
                chk("fwd_hit", fwd_g, rwg);
                chk("reg_write_u", out_reg_write_u, e.rw);
                chk("fwd_hit_u", fwd_u, e.rw);
                chk("write_reg", out_write_reg_g, e.wr);
                chk("write_reg_u", out_write_reg_u, e.wr);
                chk("mem_to_reg", out_mem_to_reg_g, e.m2r);
                chk("mem_to_reg_u", out_mem_to_reg_u, e.m2r);
                chk("wb_data", out_wb_data_g, e.m2r ? e.dm : e.alu);
                chk("wb_data_u", out_wb_data_u, e.m2r ? e.dm : e.alu);
                chk("pkt", out_pkt_g, {e.dm, e.alu, e.wr, e.m2r, rwg});
                chk("pkt_u", out_pkt_u, {e.dm, e.alu, e.wr, e.m2r, e.rw});
                if (out_ready && !flush) void'(q.pop_front());
            end else begin
                chk("pkt_idle", out_pkt_g, 71'd0);
                chk("pkt_idle_u", out_pkt_u, 71'd0);
            end
        end
    end

    task automatic drive(input bit v, input bit rw, input bit m2r, input logic [4:0] wr,
                         input logic [31:0] alu, input logic [31:0] dm);
        in_valid      = v;
        in_reg_write  = rw;
        in_mem_to_reg = m2r;
        in_write_reg  = wr;
        in_alu_out    = alu;
        in_dm_out     = dm;
    endtask

    // One clock: decide acceptance from the handshake, then update the model at the edge.
    task automatic step(output bit acc);
        bit   fl;
        ent_t n;
        @(negedge clk);
        acc = in_valid && in_ready_g && !flush;
        fl  = flush;
        n   = '{in_reg_write, in_mem_to_reg, in_write_reg, in_alu_out, in_dm_out};
        @(posedge clk);
        if (fl) q.delete();
        else if (acc) q.push_back(n);
        #1;
    endtask

    task automatic send(input bit rw, input bit m2r, input logic [4:0] wr,
                        input logic [31:0] alu, input logic [31:0] dm);
        bit acc;
        bit done;
        done = 1'b0;
        drive(1'b1, rw, m2r, wr, alu, dm);
        for (int i = 0; i < 40 && !done; i++) begin
            step(acc);
            done = acc;
        end
        if (!done) fail_now("send_accept");
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bit acc;
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) step(acc);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation bound expired");
        $fatal(1, "timeout");
    end

    initial begin
        bit acc;
        bit acc_any;
        bit need_new;
        clr = 1'b1;
        flush = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", out_valid_g, 1'b0);
        chk("reset_in_ready", in_ready_g, 1'b1);
        chk("reset_pkt", out_pkt_g, 71'd0);
        clr = 1'b0;
        mon_on = 1'b1;

        // streaming
        out_ready = 1'b1;
        send(1'b1, 1'b0, 5'd1, 32'hA, 32'h0);
        send(1'b1, 1'b0, 5'd2, 32'hB, 32'h0);
        send(1'b1, 1'b0, 5'd3, 32'hC, 32'h0);
        idle(3);

        // back-pressure fills both entries, third is held off
        out_ready = 1'b0;
        send(1'b1, 1'b0, 5'd4, 32'h11, 32'h0);
        send(1'b1, 1'b0, 5'd5, 32'h22, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 5'd6, 32'h33, 32'h0);
        acc_any = 1'b0;
        repeat (3) begin
            step(acc);
            acc_any |= acc;
        end
        chk("held_off", acc_any, 1'b0);
        out_ready = 1'b1;
        send(1'b1, 1'b0, 5'd6, 32'h33, 32'h0);
        idle(4);

        // write-back mux and $0 gate
        send(1'b1, 1'b1, 5'd7, 32'h4, 32'hDEADBEEF);
        send(1'b1, 1'b0, 5'd7, 32'h4, 32'hDEADBEEF);
        send(1'b1, 1'b0, 5'd0, 32'h5, 32'h0);
        idle(2);

        // flush while full with a new input offered
        out_ready = 1'b0;
        send(1'b1, 1'b0, 5'd8, 32'h44, 32'h0);
        send(1'b1, 1'b0, 5'd9, 32'h55, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 5'd10, 32'h66, 32'h0);
        flush = 1'b1;
        step(acc);
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", out_valid_g, 1'b0);
        chk("flush_in_ready", in_ready_g, 1'b1);
        out_ready = 1'b1;
        idle(3);

        // asynchronous clear between edges
        out_ready = 1'b0;
        send(1'b1, 1'b0, 5'd11, 32'h12345678, 32'h0);
        #1 clr = 1'b1;
        #1;
        chk("clr_out_valid", out_valid_g, 1'b0);
        chk("clr_pkt", out_pkt_g, 71'd0);
        chk("clr_in_ready", in_ready_g, 1'b1);
        q.delete();
        clr = 1'b0;
        idle(2);

        // randomized traffic
        need_new = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (need_new)
                drive($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
                      ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), $urandom, $urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 15) == 0);
            step(acc);
            need_new = acc || !in_valid || flush;
        end
        flush = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b0;
        for (int i = 0; i < 10 && q.size() != 0; i++) step(acc);
        chk("drained", q.size(), 0);
        mon_on = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
